// File: rtl/ov7670_frame_pingpong_ctrl_if.sv
// Capture-side, frame-buffer and consumer signals of the ping-pong controller.
// master = controller, slave = capture block / BRAM / consumer side.
interface ov7670_frame_pingpong_ctrl_if #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 16
);
  logic              enable;
  logic              vsync;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0]        cap_data;
  logic              cons_done;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [7:0]        mem_din;
  logic              frame_ready;
  logic              rd_bank;
  logic [CNT_W-1:0]  frame_count;
  logic [CNT_W-1:0]  drop_count;
  logic              short_frame;

  modport master (
    input  enable, vsync, cap_we, cap_addr, cap_data, cons_done,
    output mem_we, mem_addr, mem_din,
    output frame_ready, rd_bank,
    output frame_count, drop_count, short_frame
  );

  modport slave (
    output enable, vsync, cap_we, cap_addr, cap_data, cons_done,
    input  mem_we, mem_addr, mem_din,
    input  frame_ready, rd_bank,
    input  frame_count, drop_count, short_frame
  );
endinterface

// File: rtl/ov7670_frame_pingpong_ctrl.sv
// Steers OV7670 grayscale pixels into a two-bank frame buffer and hands
// completed frames to the corner detector without ever tearing a read.
module ov7670_frame_pingpong_ctrl #(
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_W       = 17,
  parameter int CNT_W        = 16
) (
  input logic pclk,
  input logic rst,
  ov7670_frame_pingpong_ctrl_if.master io
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE
  } state_e;

  localparam logic [ADDR_W-1:0] FRAME_MAX = ADDR_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic              vsync_d_q;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              frame_ready_q, frame_ready_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]  frame_count_q, frame_count_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;
  logic              short_frame_q, short_frame_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;

  logic sof;
  logic eof;
  logic accept;
  logic complete;
  logic free;
  logic handoff;
  logic publish;
  logic drop;

  always_comb begin
    sof      = vsync_d_q & ~io.vsync;
    eof      = ~vsync_d_q & io.vsync;
    accept   = io.enable & io.cap_we
             & (state_q == CAPTURE)
             & (io.cap_addr < FRAME_MAX);
    complete = (pix_cnt_q == FRAME_MAX);
    free     = ~frame_ready_q | io.cons_done;
    handoff  = io.enable & (state_q == CAPTURE) & eof;
    publish  = handoff & complete & free;
    drop     = handoff & ~(complete & free);
  end

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    frame_ready_d = frame_ready_q;
    pix_cnt_d     = pix_cnt_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    short_frame_d = handoff & ~complete;
    mem_we_d      = accept;
    mem_addr_d    = {wr_bank_q, io.cap_addr};
    mem_din_d     = io.cap_data;

    if (accept && (pix_cnt_q != FRAME_MAX)) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (io.enable) begin
          state_d = ARM;
        end
      end
      ARM: begin
        if (!io.enable) begin
          state_d = IDLE;
        end else if (sof) begin
          state_d   = CAPTURE;
          pix_cnt_d = '0;
        end
      end
      CAPTURE: begin
        if (!io.enable) begin
          state_d = IDLE;
        end else if (eof) begin
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase

    // Publishing a new bank wins over a same-cycle release of the old one.
    if (publish) begin
      rd_bank_d     = wr_bank_q;
      wr_bank_d     = ~wr_bank_q;
      frame_ready_d = 1'b1;
      frame_count_d = frame_count_q + 1'b1;
    end else if (io.cons_done && frame_ready_q) begin
      frame_ready_d = 1'b0;
    end

    if (drop && (drop_count_q != CNT_MAX)) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= IDLE;
      vsync_d_q     <= 1'b0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      pix_cnt_q     <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      short_frame_q <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
    end else begin
      state_q       <= state_d;
      vsync_d_q     <= io.vsync;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      frame_ready_q <= frame_ready_d;
      pix_cnt_q     <= pix_cnt_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      short_frame_q <= short_frame_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
    end
  end

  assign io.mem_we      = mem_we_q;
  assign io.mem_addr    = mem_addr_q;
  assign io.mem_din     = mem_din_q;
  assign io.frame_ready = frame_ready_q;
  assign io.rd_bank     = rd_bank_q;
  assign io.frame_count = frame_count_q;
  assign io.drop_count  = drop_count_q;
  assign io.short_frame = short_frame_q;

endmodule
